signal_detector: RTL and testbench
==================================

// Module: signal_detector
//
// PURPOSE
//   Single-bit input conditioner and event detector. Synchronises an
//   asynchronous or slow input into the clock domain and optionally
//   glitch-filters it. Reports its registered level and one-cycle pulses on
//   rising and falling transitions. Shared utility block for MAC/PHY status
//   lines, link/valid strobes and buttons across the switch.
//
// PARAMETERS
//   SYNC_STAGES   2  flops in the input synchroniser; 0 = input used directly
//   STABLE_CYCLES 1  consecutive differing samples needed to accept a new
//                    level; must be >=1; 1 = no filtering
//   RESET_LEVEL   0  assumed input level during/after reset (1 bit)
//
// PORTS
//   clock          in   1  single clock; all state on its rising edge
//   reset          in   1  asynchronous, active-low reset
//   signal         in   1  raw input
//   edge_positive  out  1  one-cycle pulse: filtered level went 0->1
//   edge_negative  out  1  one-cycle pulse: filtered level went 1->0
//   level_high     out  1  filtered level == 1
//   level_low      out  1  filtered level == 0
//
// BEHAVIOUR
//   - Reset (reset==0, async):
//     - sync chain <= RESET_LEVEL; filtered level f <= RESET_LEVEL; cnt <= 0.
//     - edge_positive = edge_negative = 0.
//     - level_high = RESET_LEVEL; level_low = ~RESET_LEVEL.
//   - Sync: s = last sync flop, or signal itself when SYNC_STAGES==0.
//   - Filter, each clock, using cnt of width $clog2(STABLE_CYCLES+1):
//     - s==f: cnt<=0.
//     - s!=f and cnt+1==STABLE_CYCLES: f<=s, cnt<=0, assert the edge
//       output matching the new level for exactly this one cycle.
//     - otherwise: cnt<=cnt+1.
//     - A sample equal to f mid-count clears cnt, so glitches shorter
//       than STABLE_CYCLES are dropped entirely.
//   - Outputs: all registered, no combinational path from signal.
//     - level_high = f; level_low = ~f at all times.
//     - Edge pulses are deasserted the cycle after they fire.
//   - Latency: input change sampled at edge E0 gives the new level and the
//     edge pulse after edge E0+SYNC_STAGES+STABLE_CYCLES-1.
//     - Defaults: visible after the 3rd rising edge counting from E0.
//   - edge_positive and edge_negative are never both 1.
//     - Consecutive pulses are at least STABLE_CYCLES cycles apart.
//   - Input already != RESET_LEVEL at reset release: reported as a normal
//     transition with the normal latency.
//   - Reset mid-operation: all state returns to reset values immediately.
//     - An in-flight count or pulse is discarded.
//
// TESTING (defaults unless stated; clock period 2 ns)
//   1. Hold reset low, signal=0 -> level_low=1, level_high=0, both edges 0.
//   2. Release reset; signal 0->1 before edge E0 -> level_high=1 and
//      edge_positive=1 after edge E0+2; edge_positive=0 after E0+3;
//      level_high stays 1.
//   3. Signal 1->0 -> edge_negative single pulse and level_low=1 at the same
//      latency; edge_positive stays 0 throughout.
//   4. STABLE_CYCLES=3: 2-cycle high glitch -> no edge pulse, level_high=0.
//      4-cycle high pulse -> one edge_positive, then one edge_negative.
//   5. SYNC_STAGES=0: signal rises before edge E0 -> level_high=1 and
//      edge_positive=1 right after E0.
//   6. Assert reset while edge_positive=1 -> outputs return to reset values
//      at once. Release with signal=1 -> a fresh edge_positive at normal
//      latency.

Source files
------------

// File: rtl/signal_detector.sv
// -----------------------------------------------------------------------------
// signal_detector
//
// Conditions a single-bit input and reports events on it:
//   - Optional synchroniser brings an asynchronous or slow input into the
//     clock domain.
//   - Optional glitch filter accepts a new level only after it has been seen
//     on STABLE_CYCLES consecutive samples.
//   - Reports the filtered level and one-cycle pulses on its rising and
//     falling transitions.
// Typical users are MAC/PHY status lines, link/valid strobes and buttons.
//
// Parameters
//   SYNC_STAGES   number of synchroniser flops; 0 uses the input directly
//   STABLE_CYCLES consecutive differing samples needed to change level (>=1);
//                 a value of 1 disables filtering
//   RESET_LEVEL   level the input is assumed to have during and after reset
//
// Ports
//   clock          in  single clock; all state updates on its rising edge
//   reset          in  asynchronous, active-low reset
//   signal         in  raw input
//   edge_positive  out one-cycle pulse when the filtered level goes 0->1
//   edge_negative  out one-cycle pulse when the filtered level goes 1->0
//   level_high     out filtered level is 1
//   level_low      out filtered level is 0
//
// Every output comes from a register; there is no combinational path from
// signal to any output.
// -----------------------------------------------------------------------------
module signal_detector #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 1,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic signal,
  output logic edge_positive,
  output logic edge_negative,
  output logic level_high,
  output logic level_low
);

  localparam int                 CNT_W    = $clog2(STABLE_CYCLES + 1);
  // The count value at which the next differing sample completes the run.
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;          // synchronised sample
  logic             f_q, f_d;   // filtered level
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign s = signal;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // The chain resets to RESET_LEVEL so that an input already sitting at
      // that level produces no spurious transition after reset release.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
          // NOTE: non-blocking assignments make every stage capture the value
          // its predecessor held before this edge, which is what forms the
          // shift chain; blocking assignments here would collapse it.
          sync_q[0] <= signal;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Glitch filter and edge detection: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    f_d    = f_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;

    if (s == f_q) begin
      // A sample matching the current level breaks any run in progress, so
      // glitches shorter than STABLE_CYCLES vanish completely.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      f_d    = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Filter state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_q    <= RESET_LEVEL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      f_q    <= f_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign edge_positive = rise_q;
  assign edge_negative = fall_q;
  assign level_high    = f_q;
  assign level_low     = ~f_q;

endmodule

// File: tb/tb_signal_detector.sv
// -----------------------------------------------------------------------------
// tb_signal_detector
//
// Directed bench for signal_detector. Three instances share one 2 ns clock:
//   u_a : defaults (SYNC_STAGES=2, STABLE_CYCLES=1)
//   u_b : STABLE_CYCLES=3
//   u_c : SYNC_STAGES=0
// Inputs change and outputs are sampled on the falling clock edge. Outputs are
// compared as the packed vector {edge_positive, edge_negative, level_high,
// level_low}. Index k below counts the rising edges after the first edge
// (E0) that sees the new input value, with k=0 being E0 itself.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_signal_detector;

  logic clock = 1'b0;
  always #1 clock = ~clock;

  logic rst_a, rst_b, rst_c;
  logic sig_a, sig_b, sig_c;
  logic ep_a, en_a, lh_a, ll_a;
  logic ep_b, en_b, lh_b, ll_b;
  logic ep_c, en_c, lh_c, ll_c;
  logic [3:0] obs_a, obs_b, obs_c;

  assign obs_a = {ep_a, en_a, lh_a, ll_a};
  assign obs_b = {ep_b, en_b, lh_b, ll_b};
  assign obs_c = {ep_c, en_c, lh_c, ll_c};

  int n_vec = 0;
  int n_err = 0;

  // Output encodings used in the expectations.
  localparam logic [3:0] IDLE_LOW  = 4'b0001;  // level 0, no pulse
  localparam logic [3:0] IDLE_HIGH = 4'b0010;  // level 1, no pulse
  localparam logic [3:0] ROSE      = 4'b1010;  // edge_positive, level 1
  localparam logic [3:0] FELL      = 4'b0101;  // edge_negative, level 0

  signal_detector u_a (
    .clock(clock), .reset(rst_a), .signal(sig_a),
    .edge_positive(ep_a), .edge_negative(en_a),
    .level_high(lh_a), .level_low(ll_a)
  );

  signal_detector #(.SYNC_STAGES(2), .STABLE_CYCLES(3), .RESET_LEVEL(1'b0)) u_b (
    .clock(clock), .reset(rst_b), .signal(sig_b),
    .edge_positive(ep_b), .edge_negative(en_b),
    .level_high(lh_b), .level_low(ll_b)
  );

  signal_detector #(.SYNC_STAGES(0), .STABLE_CYCLES(1), .RESET_LEVEL(1'b0)) u_c (
    .clock(clock), .reset(rst_c), .signal(sig_c),
    .edge_positive(ep_c), .edge_negative(en_c),
    .level_high(lh_c), .level_low(ll_c)
  );

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [3:0] exp;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b0;
    repeat (2) @(negedge clock);
    exp = IDLE_LOW;
    n_vec++;
    if (obs_a !== exp) begin
      n_err++; $display("FAIL reset_a: got %b want %b", obs_a, exp);
    end
    n_vec++;
    if (obs_b !== exp) begin
      n_err++; $display("FAIL reset_b: got %b want %b", obs_b, exp);
    end
    n_vec++;
    if (obs_c !== exp) begin
      n_err++; $display("FAIL reset_c: got %b want %b", obs_c, exp);
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) begin
      @(negedge clock);
      n_vec++;
      if (obs_a !== IDLE_LOW) begin
        n_err++; $display("FAIL idle_after_reset: got %b want %b", obs_a, IDLE_LOW);
      end
    end
  endtask

  // Default instance: rising input, pulse after E0+2.
  task automatic test_rise();
    logic [3:0] exp;
    sig_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      exp = (k < 2) ? IDLE_LOW : (k == 2) ? ROSE : IDLE_HIGH;
      n_vec++;
      if (obs_a !== exp) begin
        n_err++; $display("FAIL rise k=%0d: got %b want %b", k, obs_a, exp);
      end
    end
  endtask

  // Default instance: falling input, negative pulse at the same latency.
  task automatic test_fall();
    logic [3:0] exp;
    sig_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      exp = (k < 2) ? IDLE_HIGH : (k == 2) ? FELL : IDLE_LOW;
      n_vec++;
      if (obs_a !== exp) begin
        n_err++; $display("FAIL fall k=%0d: got %b want %b", k, obs_a, exp);
      end
    end
  endtask

  // STABLE_CYCLES=3: a 2-sample high glitch must be dropped.
  task automatic test_glitch();
    sig_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      n_vec++;
      if (obs_b !== IDLE_LOW) begin
        n_err++; $display("FAIL glitch k=%0d: got %b want %b", k, obs_b, IDLE_LOW);
      end
      if (k == 1) sig_b = 1'b0;
    end
  endtask

  // STABLE_CYCLES=3: a 4-sample pulse gives one rise then one fall, each
  // after a latency of 2+3-1 = 4 edges.
  task automatic test_pulse();
    logic [3:0] exp;
    sig_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (k < 4)       exp = IDLE_LOW;
      else if (k == 4) exp = ROSE;
      else if (k < 8)  exp = IDLE_HIGH;
      else if (k == 8) exp = FELL;
      else             exp = IDLE_LOW;
      n_vec++;
      if (obs_b !== exp) begin
        n_err++; $display("FAIL pulse k=%0d: got %b want %b", k, obs_b, exp);
      end
      if (k == 3) sig_b = 1'b0;
    end
  endtask

  // SYNC_STAGES=0: change appears right after E0.
  task automatic test_no_sync();
    logic [3:0] exp;
    sig_c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      exp = (k == 0) ? ROSE : (k == 1) ? IDLE_HIGH : (k == 2) ? FELL : IDLE_LOW;
      n_vec++;
      if (obs_c !== exp) begin
        n_err++; $display("FAIL no_sync k=%0d: got %b want %b", k, obs_c, exp);
      end
      if (k == 1) sig_c = 1'b0;
    end
  endtask

  // Reset while edge_positive is high, then release with the input high.
  task automatic test_reset_mid();
    logic [3:0] exp;
    sig_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      exp = (k == 2) ? ROSE : IDLE_LOW;
      n_vec++;
      if (obs_a !== exp) begin
        n_err++; $display("FAIL pre_reset k=%0d: got %b want %b", k, obs_a, exp);
      end
    end
    rst_a = 1'b0;
    #0.5;
    n_vec++;
    if (obs_a !== IDLE_LOW) begin
      n_err++; $display("FAIL async_reset: got %b want %b", obs_a, IDLE_LOW);
    end
    @(negedge clock);
    n_vec++;
    if (obs_a !== IDLE_LOW) begin
      n_err++; $display("FAIL held_reset: got %b want %b", obs_a, IDLE_LOW);
    end
    rst_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      exp = (k < 2) ? IDLE_LOW : (k == 2) ? ROSE : IDLE_HIGH;
      n_vec++;
      if (obs_a !== exp) begin
        n_err++; $display("FAIL post_reset k=%0d: got %b want %b", k, obs_a, exp);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_pulse();
    test_no_sync();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
